mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequential arbiter that shares one single-port data/instruction memory between the instruction-fetch path and the load/store path of the core. It accepts one request at a time, forwards it to the memory port, waits a variable number of cycles for completion, and returns read data with a one-cycle acknowledge. It includes a watchdog that terminates hung memory transactions with an error. It sits between the core (PC/fetch and Mem-stage requesters) and a shared multi-cycle memory; the core stalls on `busy`.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `TO_CYCLES`, 255, watchdog limit in WAIT cycles (1..255; counter is 8 bits)

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `if_req`  in  1  fetch request; held until `if_ack`
- `if_addr`  in  AW  fetch address (word read)
- `d_req`  in  1  data request; held until `d_ack`
- `d_we`  in  1  1 = store, 0 = load
- `d_funct3`  in  3  access size/sign, passed through to memory
- `d_addr`  in  AW  data address
- `d_wdata`  in  DW  store data
- `if_ack`  out  1  one-cycle fetch completion
- `d_ack`  out  1  one-cycle data completion
- `rdata`  out  DW  read data, valid while an ack is high
- `err`  out  1  high with the ack when the watchdog expired
- `busy`  out  1  high in every state except IDLE
- `m_req`  out  1  one-cycle memory command strobe
- `m_we`, `m_addr`, `m_wdata`, `m_funct3`  out  1/AW/DW/3  registered command fields
- `m_valid`  in  1  memory completion strobe
- `m_rdata`  in  DW  memory read data, valid with `m_valid`

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: if any req is high, register the winner's fields, set the grant, and go to REQ. Fetch commands use `m_we`=0 and `m_funct3`=3'b010; `m_wdata` is 0.
- REQ: `m_req`=1 for exactly one cycle, then go to WAIT and clear the watchdog.
- WAIT, normal completion: on `m_valid`, capture `m_rdata` into `rdata` (0 for stores), clear `err`, and go to RESP.
- WAIT, timeout: otherwise the watchdog increments. When it reaches `TO_CYCLES` without `m_valid`, set `rdata`=0 and `err`=1, then go to RESP.
- RESP: assert the granted ack for one cycle, then go to IDLE. Requests are not sampled in RESP.
- Arbitration on a tie in IDLE: data wins (see Configuration). A single requester always wins.
- Exactly one transaction is outstanding at any time. `m_valid` outside WAIT is ignored.
- Requesters must hold fields stable from raising req until ack, and must drop req or present a new request the cycle after ack.
- Reset values: state IDLE; all acks, `err`, `busy`, `m_req`, and `m_we` at 0; `m_addr`, `m_wdata`, `m_funct3`, and `rdata` at 0; watchdog 0; last-grant = fetch.
- Reset mid-operation: the transaction is dropped with no ack. A late `m_valid` after reset is ignored.

## Timing
- Request seen at edge N → REQ (`m_req`) in cycle N+1 → WAIT from N+2.
- `m_valid` in cycle N+1+k (k ≥ 1) → ack in cycle N+2+k.
- Minimum req-to-ack latency is 3 cycles, for a memory that answers the cycle after `m_req`.
- Back-to-back throughput: a new request may be granted at the edge ending the cycle after RESP. The minimum period is 4 cycles per access.
- Timeout: ack with `err` occurs `TO_CYCLES`+1 cycles after entering WAIT.
- `busy` is registered and equals (state ≠ IDLE).

## Configuration
- `MEM_ARB_RR_EN` defined: ties alternate by round-robin. The grant goes to the requester not served last. Last-grant resets to fetch, so the first tie goes to data.
- `MEM_ARB_RR_EN` undefined: fixed priority, data always wins ties. The last-grant register is not built.

## Test plan
- Reset mid-transaction: fetch in WAIT, `rst`=1 for 1 cycle → state IDLE, no `if_ack`; a `m_valid` asserted 2 cycles later → no ack.
- Single fetch, 1-cycle memory: `if_req`, `if_addr`=0x0000_0040, `m_rdata`=0x0010_0093 → `m_req` at N+1 with `m_addr`=0x40, `if_ack` at N+3 with `rdata`=0x0010_0093 and `err`=0.
- Store, 4-cycle memory: `d_req`, `d_we`=1, `d_addr`=0x100, `d_wdata`=0xDEAD_BEEF, `d_funct3`=3'b010 → `m_we`=1 with fields passed through, `d_ack` at N+6, `rdata`=0.
- Tie with macro undefined: `if_req` and `d_req` high together, both re-raised after each ack, 3 rounds → data served 3 times before any fetch. With `MEM_ARB_RR_EN` defined → order data, fetch, data.
- Watchdog: `TO_CYCLES`=8, memory never asserts `m_valid` → `d_ack`=1 with `err`=1 and `rdata`=0, 9 cycles after entering WAIT; next request completes normally with `err`=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one multi-cycle memory port between fetch and load/store, with watchdog (round-robin ties under MEM_ARB_RR_EN)
module mem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int TO_CYCLES = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [2:0]    d_funct3,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          if_ack,
  output logic          d_ack,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          busy,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic [2:0]    m_funct3,
  input  logic          m_valid,
  input  logic [DW-1:0] m_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  localparam logic [7:0] TO = 8'(TO_CYCLES);
  state_t state_q, state_d;
  logic [7:0] wd_q, wd_d;
  logic grant_q, grant_d;
  logic if_ack_q, if_ack_d, d_ack_q, d_ack_d, err_q, err_d, busy_q, busy_d;
  logic m_req_q, m_req_d, m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d, rdata_q, rdata_d;
  logic [2:0] m_funct3_q, m_funct3_d;
  logic pick;
`ifdef MEM_ARB_RR_EN
  logic last_q, last_d;
  assign pick = d_req & ~(if_req & last_q);
  // remember who was granted last so the next tie goes the other way
  always_comb last_d = (state_q == IDLE && (if_req | d_req)) ? pick : last_q;
  // last-grant register, reset to fetch so the first tie goes to data
  always_ff @(posedge clk) last_q <= rst ? 1'b0 : last_d;
`else
  assign pick = d_req;
`endif
  // next state, command capture, watchdog and response generation
  always_comb begin
    state_d    = state_q;
    wd_d       = wd_q;
    grant_d    = grant_q;
    m_req_d    = 1'b0;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_funct3_d = m_funct3_q;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      IDLE: if (if_req | d_req) begin
        state_d    = REQ;
        grant_d    = pick;
        m_req_d    = 1'b1;
        m_we_d     = pick & d_we;
        m_addr_d   = pick ? d_addr : if_addr;
        m_wdata_d  = pick ? d_wdata : '0;
        m_funct3_d = pick ? d_funct3 : 3'b010;
      end
      REQ: begin
        state_d = WAIT;
        wd_d    = '0;
      end
      WAIT: if (m_valid || wd_q == TO) begin
        state_d  = RESP;
        rdata_d  = (m_valid && !m_we_q) ? m_rdata : '0;
        err_d    = !m_valid;
        if_ack_d = !grant_q;
        d_ack_d  = grant_q;
      end else begin
        wd_d = wd_q + 8'd1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wd_q       <= '0;
      grant_q    <= 1'b0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_funct3_q <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wd_q       <= wd_d;
      grant_q    <= grant_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      m_funct3_q <= m_funct3_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end
  assign if_ack   = if_ack_q;
  assign d_ack    = d_ack_q;
  assign rdata    = rdata_q;
  assign err      = err_q;
  assign busy     = busy_q;
  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign m_funct3 = m_funct3_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors, tie/reset sequences and random transactions against a transaction-level model
module tb_mem_arbiter;
  localparam int TO = 8;
  logic clk = 1'b0, rst = 1'b1;
  logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, m_valid = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, m_rdata = '0;
  logic [2:0] d_funct3 = '0;
  logic if_ack, d_ack, err, busy, m_req, m_we;
  logic [31:0] rdata, m_addr, m_wdata;
  logic [2:0] m_funct3;
  int total = 0, passed = 0;
  logic [31:0] dev_mem [256];
  logic [31:0] ref_mem [256];
  typedef struct {
    bit dsel, we;
    logic [2:0] f3;
    logic [31:0] addr, wdata, mdata;
    int k;
    logic [31:0] exp_rdata;
    bit exp_err;
    int exp_lat;
  } vec_t;
  vec_t tbl [7];

  always #5 clk = ~clk;

  mem_arbiter #(.AW(32), .DW(32), .TO_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .d_req(d_req), .d_we(d_we),
    .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata), .if_ack(if_ack), .d_ack(d_ack),
    .rdata(rdata), .err(err), .busy(busy), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_funct3(m_funct3), .m_valid(m_valid), .m_rdata(m_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // one full transaction; k = cycles from m_req to m_valid, 0 = memory never answers
  task automatic txn(input bit dsel, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input bit use_dev, input logic [31:0] mdata, input int k,
                     input logic [31:0] exp_rdata, input bit exp_err, input int exp_lat);
    int n;
    m_valid = 1'b0;
    if (dsel) begin
      d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
      d_we = 1'($urandom); d_wdata = $urandom; d_funct3 = 3'($urandom);
    end
    @(negedge clk);
    chk("m_req", 32'(m_req), 32'd1);
    chk("busy", 32'(busy), 32'd1);
    chk("m_addr", m_addr, addr);
    chk("m_we", 32'(m_we), 32'(dsel & we));
    chk("m_wdata", m_wdata, dsel ? wdata : 32'd0);
    chk("m_funct3", 32'(m_funct3), dsel ? 32'(f3) : 32'd2);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk("m_req_pulse", 32'(m_req), 32'd0);
      m_valid = (k > 0 && n == k);
      m_rdata = $urandom;
      if (m_valid) begin
        m_rdata = use_dev ? dev_mem[m_addr[9:2]] : mdata;
        if (m_we) dev_mem[m_addr[9:2]] = m_wdata;
      end
    end while (!(if_ack | d_ack) && n < 300);
    chk("ack_latency", 32'(n), 32'(exp_lat));
    chk("if_ack", 32'(if_ack), 32'(!dsel));
    chk("d_ack", 32'(d_ack), 32'(dsel));
    chk("rdata", rdata, exp_rdata);
    chk("err", 32'(err), 32'(exp_err));
    if (dsel && we && k > 0) ref_mem[addr[9:2]] = wdata;
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
    chk("ack_one_cycle", {30'd0, if_ack, d_ack}, 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    bit [2:0] exp_order;
    logic [31:0] ar, wr;
    bit ds, we;
    int k, kk;
    for (int i = 0; i < 256; i++) begin
      dev_mem[i] = $urandom;
      ref_mem[i] = dev_mem[i];
    end
    tbl[0] = '{0, 0, 3'b010, 32'h40,  32'h0,         32'h0010_0093, 1, 32'h0010_0093, 0, 2};
    tbl[1] = '{1, 1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h1234_5678, 4, 32'h0,         0, 5};
    tbl[2] = '{1, 0, 3'b100, 32'h104, 32'h0,         32'h0000_0080, 2, 32'h0000_0080, 0, 3};
    tbl[3] = '{1, 1, 3'b000, 32'h108, 32'h55,        32'h0,         0, 32'h0,         1, TO + 2};
    tbl[4] = '{0, 0, 3'b010, 32'h44,  32'h0,         32'h0000_0013, 3, 32'h0000_0013, 0, 4};
    tbl[5] = '{1, 0, 3'b001, 32'h10C, 32'h0,         32'h0000_A5A5, TO + 1, 32'h0000_A5A5, 0, TO + 2};
    tbl[6] = '{0, 0, 3'b010, 32'h48,  32'h0,         32'hFFFF_FFFF, 0, 32'h0,         1, TO + 2};
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_m_we", 32'(m_we), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_m_funct3", 32'(m_funct3), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 7; i++)
      txn(tbl[i].dsel, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, 1'b0, tbl[i].mdata,
          tbl[i].k, tbl[i].exp_rdata, tbl[i].exp_err, tbl[i].exp_lat);
    if_req = 1'b1; if_addr = 32'h80;
    repeat (3) @(negedge clk);
    rst = 1'b1; if_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_acks", {30'd0, if_ack, d_ack}, 32'd0);
    chk("midrst_m_req", 32'(m_req), 32'd0);
    chk("midrst_m_addr", m_addr, 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    @(negedge clk);
    m_valid = 1'b1; m_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    m_valid = 1'b0;
    chk("late_valid_ack", {30'd0, if_ack, d_ack}, 32'd0);
    chk("late_valid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("late_valid_ack2", {30'd0, if_ack, d_ack}, 32'd0);
    chk("late_valid_busy2", 32'(busy), 32'd0);
`ifdef MEM_ARB_RR_EN
    exp_order = 3'b101;
`else
    exp_order = 3'b111;
`endif
    if_req = 1'b1; if_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_funct3 = 3'b010;
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      chk("tie_m_req", 32'(m_req), 32'd1);
      chk("tie_grant", m_addr, exp_order[r] ? 32'h300 : 32'h200);
      @(negedge clk);
      m_valid = 1'b1; m_rdata = 32'(r);
      @(negedge clk);
      m_valid = 1'b0;
      chk("tie_ack", {30'd0, if_ack, d_ack}, exp_order[r] ? 32'd1 : 32'd2);
      @(negedge clk);
    end
    if_req = 1'b0; d_req = 1'b0;
    for (int t = 0; t < 40; t++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        m_valid = 1'($urandom); m_rdata = $urandom;
        @(negedge clk);
        chk("idle_no_ack", {30'd0, if_ack, d_ack}, 32'd0);
      end
      ds = 1'($urandom);
      we = ds & 1'($urandom);
      ar = {22'd0, 8'($urandom), 2'b00};
      wr = $urandom;
      kk = int'($urandom_range(0, 5));
      k = (kk == 0) ? 0 : int'($urandom_range(1, TO + 1));
      txn(ds, we, 3'($urandom), ar, wr, 1'b1, 32'd0, k,
          (k == 0 || we) ? 32'd0 : ref_mem[ar[9:2]], k == 0, (k == 0) ? TO + 2 : k + 1);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
